// File: rtl/inst_fetcher.sv
// Instruction fetch stage: walks the PC through the Icache, fetches misses from the
// memory controller, fills the Icache and issues {inst, pc} pulses to the decoder.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic [31:0] if_to_ic_inst_addr,
    input  logic        ic_to_if_hit,
    input  logic [31:0] ic_to_if_hit_inst,
    output logic [31:0] if_to_ic_inst,
    output logic        if_to_ic_ready,

    output logic        if_to_mc_req,
    output logic [31:0] if_to_mc_addr,
    input  logic        mc_to_if_done,
    input  logic [31:0] mc_to_if_inst,

    input  logic        dc_to_if_stall,
    output logic        if_to_dc_valid,
    output logic [31:0] if_to_dc_inst,
    output logic [31:0] if_to_dc_pc,

    input  logic        rob_to_if_jump,
    input  logic [31:0] rob_to_if_jump_addr
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_MISS    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        fill_hit;

    // While a miss is outstanding or its fill is being strobed, the Icache port
    // carries the miss address; otherwise it looks up the current PC.
    assign if_to_ic_inst_addr = ((state != ST_FETCH) || if_to_ic_ready) ? if_to_mc_addr : pc;

    // During the fill cycle the fetched word is forwarded straight to the decoder
    // when the PC still points at the filled line, so no second lookup is needed.
    assign fill_hit = if_to_ic_ready && (pc == if_to_mc_addr);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            if_to_mc_req   <= 1'b0;
            if_to_mc_addr  <= 32'h0;
            if_to_ic_ready <= 1'b0;
            if_to_ic_inst  <= 32'h0;
            if_to_dc_valid <= 1'b0;
            if_to_dc_inst  <= 32'h0;
            if_to_dc_pc    <= 32'h0;
        end else if (!rdy_in) begin
            if_to_dc_valid <= 1'b0;
            if_to_ic_ready <= 1'b0;
        end else begin
            if_to_dc_valid <= 1'b0;
            if_to_ic_ready <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (rob_to_if_jump) begin
                        pc <= rob_to_if_jump_addr;
                    end else if (dc_to_if_stall) begin
                        pc <= pc;
                    end else if (if_to_ic_ready) begin
                        // Fill cycle: the lookup port is busy with the fill address.
                        if (fill_hit) begin
                            if_to_dc_valid <= 1'b1;
                            if_to_dc_inst  <= if_to_ic_inst;
                            if_to_dc_pc    <= pc;
                            pc             <= pc + 32'd4;
                        end
                    end else if (ic_to_if_hit) begin
                        if_to_dc_valid <= 1'b1;
                        if_to_dc_inst  <= ic_to_if_hit_inst;
                        if_to_dc_pc    <= pc;
                        pc             <= pc + 32'd4;
                    end else begin
                        if_to_mc_req  <= 1'b1;
                        if_to_mc_addr <= pc;
                        state         <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (mc_to_if_done) begin
                        if_to_mc_req   <= 1'b0;
                        if_to_ic_ready <= 1'b1;
                        if_to_ic_inst  <= mc_to_if_inst;
                        state          <= ST_FETCH;
                        if (rob_to_if_jump) begin
                            pc <= rob_to_if_jump_addr;
                        end
                    end else if (rob_to_if_jump) begin
                        pc    <= rob_to_if_jump_addr;
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    // The request cannot be cancelled; wait it out and only fill.
                    if (rob_to_if_jump) begin
                        pc <= rob_to_if_jump_addr;
                    end
                    if (mc_to_if_done) begin
                        if_to_mc_req   <= 1'b0;
                        if_to_ic_ready <= 1'b1;
                        if_to_ic_inst  <= mc_to_if_inst;
                        state          <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: reset, table-driven hit path, hand-written
// miss/jump/freeze/reset sequences and a randomized run against a stream model.
module tb_inst_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] if_to_ic_inst_addr;
    logic        ic_to_if_hit;
    logic [31:0] ic_to_if_hit_inst;
    logic [31:0] if_to_ic_inst;
    logic        if_to_ic_ready;
    logic        if_to_mc_req;
    logic [31:0] if_to_mc_addr;
    logic        mc_to_if_done;
    logic [31:0] mc_to_if_inst;
    logic        dc_to_if_stall;
    logic        if_to_dc_valid;
    logic [31:0] if_to_dc_inst;
    logic [31:0] if_to_dc_pc;
    logic        rob_to_if_jump;
    logic [31:0] rob_to_if_jump_addr;

    inst_fetcher #(.RESET_PC(32'h0)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .if_to_ic_inst_addr  (if_to_ic_inst_addr),
        .ic_to_if_hit        (ic_to_if_hit),
        .ic_to_if_hit_inst   (ic_to_if_hit_inst),
        .if_to_ic_inst       (if_to_ic_inst),
        .if_to_ic_ready      (if_to_ic_ready),
        .if_to_mc_req        (if_to_mc_req),
        .if_to_mc_addr       (if_to_mc_addr),
        .mc_to_if_done       (mc_to_if_done),
        .mc_to_if_inst       (mc_to_if_inst),
        .dc_to_if_stall      (dc_to_if_stall),
        .if_to_dc_valid      (if_to_dc_valid),
        .if_to_dc_inst       (if_to_dc_inst),
        .if_to_dc_pc         (if_to_dc_pc),
        .rob_to_if_jump      (rob_to_if_jump),
        .rob_to_if_jump_addr (rob_to_if_jump_addr)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic [31:0] inst;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        vecs [16];
    int          checks;
    int          errors;
    int          issue_count;
    logic [31:0] cache_data [logic [31:0]];
    logic        force_hit;
    logic [31:0] force_inst;
    logic        auto_mc;
    logic        mc_busy;
    int          mc_left;
    logic        model_en;
    logic [31:0] exp_pc;
    logic        req_prev;
    logic [31:0] addr_prev;

    // Backing memory contents seen by the memory controller in the random phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_idle();
        rdy_in         = 1'b1;
        dc_to_if_stall = 1'b0;
        rob_to_if_jump = 1'b0;
        mc_to_if_done  = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_in   = 1'b0;
        mc_busy  = 1'b0;
        req_prev = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    // One clock: serve Icache/MC, record fills, advance, then check the stream model.
    task automatic tick();
        logic        rdy_s;
        logic        stall_s;
        logic        jump_s;
        logic [31:0] jaddr_s;
        if (force_hit) begin
            ic_to_if_hit      = 1'b1;
            ic_to_if_hit_inst = force_inst;
        end else if (cache_data.exists(if_to_ic_inst_addr)) begin
            ic_to_if_hit      = 1'b1;
            ic_to_if_hit_inst = cache_data[if_to_ic_inst_addr];
        end else begin
            ic_to_if_hit      = 1'b0;
            ic_to_if_hit_inst = 32'h0;
        end
        if (auto_mc) begin
            mc_to_if_done = 1'b0;
            if (if_to_mc_req) begin
                if (!mc_busy) begin
                    mc_busy = 1'b1;
                    mc_left = $urandom_range(0, 5);
                end
                if (mc_left == 0) begin
                    mc_to_if_done = 1'b1;
                    mc_to_if_inst = mem_word(if_to_mc_addr);
                    mc_busy       = 1'b0;
                end else begin
                    mc_left--;
                end
            end
        end
        if (if_to_ic_ready) begin
            cache_data[if_to_ic_inst_addr] = if_to_ic_inst;
            if (model_en) checkOutput("rnd_fill_data", if_to_ic_inst, mem_word(if_to_ic_inst_addr));
        end
        if (model_en && req_prev && if_to_mc_req) checkOutput("rnd_mc_addr_stable", if_to_mc_addr, addr_prev);
        req_prev = if_to_mc_req;
        addr_prev = if_to_mc_addr;
        rdy_s   = rdy_in;
        stall_s = dc_to_if_stall;
        jump_s  = rob_to_if_jump;
        jaddr_s = rob_to_if_jump_addr;
        @(posedge clk_in);
        #1;
        if (model_en) begin
            if (!rdy_s) begin
                checkOutput("rnd_frozen_valid", if_to_dc_valid, 1'b0);
                checkOutput("rnd_frozen_fill", if_to_ic_ready, 1'b0);
            end
            if (if_to_dc_valid) begin
                issue_count++;
                checkOutput("rnd_issue_allowed", rdy_s && !stall_s && !jump_s, 1'b1);
                checkOutput("rnd_issue_pc", if_to_dc_pc, exp_pc);
                checkOutput("rnd_issue_inst", if_to_dc_inst, mem_word(if_to_dc_pc));
                exp_pc = if_to_dc_pc + 32'd4;
            end
            if (rdy_s && jump_s) exp_pc = jaddr_s;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rdy_in              = v.rdy;
        dc_to_if_stall      = v.stall;
        rob_to_if_jump      = v.jump;
        rob_to_if_jump_addr = v.jaddr;
        force_inst          = v.inst;
        tick();
    endtask

    // Drive a jump to a target from FETCH, then let the next lookup run (miss expected).
    task automatic start_miss(input logic [31:0] target);
        rob_to_if_jump      = 1'b1;
        rob_to_if_jump_addr = target;
        tick();
        rob_to_if_jump = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; issue_count = 0;
        force_hit = 1'b1; force_inst = 32'h13; auto_mc = 1'b0; model_en = 1'b0;
        mc_to_if_inst = 32'h0; rob_to_if_jump_addr = 32'h0; exp_pc = 32'h0;
        ic_to_if_hit = 1'b0; ic_to_if_hit_inst = 32'h0;
        do_reset();

        checkOutput("reset_valid", if_to_dc_valid, 1'b0);
        checkOutput("reset_req", if_to_mc_req, 1'b0);
        checkOutput("reset_fetch_addr", if_to_ic_inst_addr, 32'h0);
        checkOutput("reset_fill", if_to_ic_ready, 1'b0);
        checkOutput("reset_dc_pc", if_to_dc_pc, 32'h0);

        // Hit path with stall, jump priority, freeze and PC wrap.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b1, 32'h0,        32'h4};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00100093, 1'b1, 32'h4,        32'h8};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00200113, 1'b1, 32'h8,        32'hC};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h00000011, 1'b0, 32'h0,        32'hC};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h00000011, 1'b0, 32'h0,        32'hC};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h00000011, 1'b0, 32'h0,        32'hC};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000011, 1'b1, 32'hC,        32'h10};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h200,      32'h00000022, 1'b0, 32'h0,        32'h200};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000033, 1'b1, 32'h200,      32'h204};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00000033, 1'b0, 32'h0,        32'h204};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h400,      32'h00000033, 1'b0, 32'h0,        32'h204};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h300,      32'h00000033, 1'b0, 32'h0,        32'h300};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000044, 1'b1, 32'h300,      32'h304};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000044, 1'b0, 32'h0,        32'hFFFFFFFC};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000055, 1'b1, 32'hFFFFFFFC, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000066, 1'b1, 32'h0,        32'h4};
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_valid", i), if_to_dc_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_pc", i), if_to_dc_pc, vecs[i].exp_pc);
                checkOutput($sformatf("vec%0d_inst", i), if_to_dc_inst, vecs[i].inst);
            end
            checkOutput($sformatf("vec%0d_addr", i), if_to_ic_inst_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_req", i), if_to_mc_req, 1'b0);
        end
        force_hit = 1'b0;

        // Cold miss at 0x100, done on the fifth request cycle.
        do_reset();
        cache_data.delete();
        start_miss(32'h100);
        checkOutput("miss_req_c1", if_to_mc_req, 1'b1);
        checkOutput("miss_addr_c1", if_to_mc_addr, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("miss_req_c%0d", i + 2), if_to_mc_req, 1'b1);
            checkOutput($sformatf("miss_addr_c%0d", i + 2), if_to_mc_addr, 32'h100);
            checkOutput($sformatf("miss_nofill_c%0d", i + 2), if_to_ic_ready, 1'b0);
        end
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'hDEADBEEF;
        tick();
        mc_to_if_done = 1'b0;
        checkOutput("miss_req_drop", if_to_mc_req, 1'b0);
        checkOutput("miss_fill_strobe", if_to_ic_ready, 1'b1);
        checkOutput("miss_fill_data", if_to_ic_inst, 32'hDEADBEEF);
        checkOutput("miss_fill_addr", if_to_ic_inst_addr, 32'h100);
        checkOutput("miss_no_early_issue", if_to_dc_valid, 1'b0);
        tick();
        checkOutput("miss_single_strobe", if_to_ic_ready, 1'b0);
        checkOutput("miss_issue_valid", if_to_dc_valid, 1'b1);
        checkOutput("miss_issue_pc", if_to_dc_pc, 32'h100);
        checkOutput("miss_issue_inst", if_to_dc_inst, 32'hDEADBEEF);

        // Jump while the miss is outstanding: fill still happens, 0x100 never issues.
        do_reset();
        cache_data.delete();
        cache_data[32'h200] = 32'h00200213;
        start_miss(32'h100);
        tick();
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h200;
        tick();
        rob_to_if_jump = 1'b0;
        checkOutput("disc_req_held", if_to_mc_req, 1'b1);
        checkOutput("disc_addr_held", if_to_mc_addr, 32'h100);
        repeat (2) tick();
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'hCAFE0100;
        tick();
        mc_to_if_done = 1'b0;
        checkOutput("disc_fill_strobe", if_to_ic_ready, 1'b1);
        checkOutput("disc_fill_addr", if_to_ic_inst_addr, 32'h100);
        checkOutput("disc_fill_data", if_to_ic_inst, 32'hCAFE0100);
        checkOutput("disc_no_issue", if_to_dc_valid, 1'b0);
        tick();
        checkOutput("disc_no_issue_fill", if_to_dc_valid, 1'b0);
        checkOutput("disc_next_addr", if_to_ic_inst_addr, 32'h200);
        tick();
        checkOutput("disc_issue_valid", if_to_dc_valid, 1'b1);
        checkOutput("disc_issue_pc", if_to_dc_pc, 32'h200);

        // Jump and done in the same cycle.
        do_reset();
        cache_data.delete();
        cache_data[32'h200] = 32'h00200213;
        start_miss(32'h100);
        tick();
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'hABCD0100;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h200;
        tick();
        mc_to_if_done = 1'b0; rob_to_if_jump = 1'b0;
        checkOutput("jd_fill_strobe", if_to_ic_ready, 1'b1);
        checkOutput("jd_fill_addr", if_to_ic_inst_addr, 32'h100);
        checkOutput("jd_no_issue", if_to_dc_valid, 1'b0);
        checkOutput("jd_req_drop", if_to_mc_req, 1'b0);
        tick();
        checkOutput("jd_no_issue_fill", if_to_dc_valid, 1'b0);
        checkOutput("jd_next_addr", if_to_ic_inst_addr, 32'h200);
        tick();
        checkOutput("jd_issue_pc", if_to_dc_valid ? if_to_dc_pc : 32'hFFFFFFFF, 32'h200);

        // Freeze mid-miss: a jump while frozen must not be taken.
        do_reset();
        cache_data.delete();
        start_miss(32'h100);
        rdy_in = 1'b0; rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h300;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("frz_req_%0d", i), if_to_mc_req, 1'b1);
            checkOutput($sformatf("frz_addr_%0d", i), if_to_mc_addr, 32'h100);
            checkOutput($sformatf("frz_fill_%0d", i), if_to_ic_ready, 1'b0);
        end
        rdy_in = 1'b1; rob_to_if_jump = 1'b0;
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'h0100ABCD;
        tick();
        mc_to_if_done = 1'b0;
        checkOutput("frz_fill_after", if_to_ic_ready, 1'b1);
        tick();
        checkOutput("frz_issue_valid", if_to_dc_valid, 1'b1);
        checkOutput("frz_issue_pc", if_to_dc_pc, 32'h100);
        checkOutput("frz_issue_inst", if_to_dc_inst, 32'h0100ABCD);

        // Asynchronous reset in the middle of a miss, then a stray done.
        do_reset();
        cache_data.delete();
        cache_data[32'hFC] = 32'h0FC00013;
        cache_data[32'h0]  = 32'h00000013;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'hFC;
        tick();
        rob_to_if_jump = 1'b0;
        tick();
        checkOutput("rst_pre_issue_pc", if_to_dc_pc, 32'hFC);
        tick();
        checkOutput("rst_pre_req", if_to_mc_req, 1'b1);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("rst_async_req", if_to_mc_req, 1'b0);
        checkOutput("rst_async_mc_addr", if_to_mc_addr, 32'h0);
        checkOutput("rst_async_dc_pc", if_to_dc_pc, 32'h0);
        checkOutput("rst_async_dc_inst", if_to_dc_inst, 32'h0);
        checkOutput("rst_async_valid", if_to_dc_valid, 1'b0);
        checkOutput("rst_async_fill", if_to_ic_ready, 1'b0);
        checkOutput("rst_async_fill_data", if_to_ic_inst, 32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        checkOutput("rst_release_addr", if_to_ic_inst_addr, 32'h0);
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'h77777777;
        tick();
        mc_to_if_done = 1'b0;
        checkOutput("rst_stray_done_fill", if_to_ic_ready, 1'b0);
        checkOutput("rst_issue_pc", if_to_dc_valid ? if_to_dc_pc : 32'hFFFFFFFF, 32'h0);
        checkOutput("rst_issue_inst", if_to_dc_inst, 32'h00000013);

        // Randomized traffic against the instruction-stream model.
        do_reset();
        cache_data.delete();
        auto_mc = 1'b1; model_en = 1'b1; exp_pc = 32'h0; issue_count = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy_in              = ($urandom % 10) != 0;
            dc_to_if_stall      = ($urandom % 5) == 0;
            rob_to_if_jump      = ($urandom % 32) == 0;
            rob_to_if_jump_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            tick();
        end
        model_en = 1'b0;
        checkOutput("rnd_progress", issue_count >= 100, 1'b1);
        $display("[TB] random phase issued %0d instructions", issue_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
